// File: rtl/loby_driver.sv
// loby_driver: host-side sequencer for the LoBy absorb/squeeze core.
// Captures a key on start, pulses init, feeds 64-bit message words using the
// core's two-cycle din timing, applies domain separation on the last word,
// squeezes once and streams the 257-bit digest out as 64-bit words.
module loby_driver #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DIG_WORDS = 5
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               start,
    input  logic [256:0]       key_in,
    input  logic [63:0]        msg_data,
    input  logic               msg_valid,
    input  logic               msg_last,
    output logic               msg_ready,
    output logic               loby_init,
    output logic [256:0]       loby_key,
    output logic [63:0]        loby_din,
    output logic               loby_din_valid,
    output logic               loby_sqz,
    input  logic [256:0]       loby_dout,
    output logic [63:0]        dig_data,
    output logic               dig_valid,
    output logic               dig_last,
    input  logic               dig_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   words_absorbed
);

    localparam int unsigned IDX_W = (DIG_WORDS > 1) ? $clog2(DIG_WORDS) : 1;
    localparam int unsigned PAD_W = DIG_WORDS * 64;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_INIT_GAP,
        S_WAIT_W,
        S_ABS_V,
        S_ABS_H,
        S_SQZ_GAP,
        S_SQZ,
        S_OUT
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [256:0]       r_key_q;
    logic [256:0]       r_dig_q;
    logic [63:0]        r_din_q;
    logic               r_last_q;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_words;

    logic               w_start_acc;
    logic               w_msg_acc;
    logic               w_dig_acc;
    logic               w_idx_last;
    logic [PAD_W-1:0]   w_dig_pad;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_msg_acc   = (r_state == S_WAIT_W) && msg_valid;
    assign w_dig_acc   = (r_state == S_OUT) && dig_ready;
    assign w_idx_last  = (r_idx == IDX_W'(DIG_WORDS - 1));

    // Zero-extend the digest to whole words so the top word carries only bit 256.
    assign w_dig_pad = {{(PAD_W - 257){1'b0}}, r_dig_q};

    // Key and data paths to the core are plain register copies.
    assign loby_key       = r_key_q;
    assign loby_din       = r_din_q;
    assign words_absorbed = r_words;

    // State register.
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_INIT;
            S_INIT:     w_next = S_INIT_GAP;
            S_INIT_GAP: w_next = S_WAIT_W;
            S_WAIT_W:   if (msg_valid) w_next = S_ABS_V;
            S_ABS_V:    w_next = S_ABS_H;
            S_ABS_H:    w_next = r_last_q ? S_SQZ_GAP : S_WAIT_W;
            S_SQZ_GAP:  w_next = S_SQZ;
            S_SQZ:      w_next = S_OUT;
            S_OUT:      if (dig_ready && w_idx_last) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output decode: every control is a pure function of state and registers.
    always_comb begin
        msg_ready      = 1'b0;
        loby_init      = 1'b0;
        loby_din_valid = 1'b0;
        loby_sqz       = 1'b0;
        dig_valid      = 1'b0;
        dig_last       = 1'b0;
        dig_data       = '0;
        busy           = (r_state != S_IDLE);
        case (r_state)
            S_INIT:   loby_init = 1'b1;
            S_WAIT_W: msg_ready = 1'b1;
            S_ABS_V:  loby_din_valid = 1'b1;
            S_ABS_H:  loby_sqz = r_last_q;
            S_SQZ:    loby_sqz = 1'b1;
            S_OUT: begin
                dig_valid = 1'b1;
                dig_last  = w_idx_last;
                for (int unsigned w = 0; w < DIG_WORDS; w++) begin
                    if (32'(r_idx) == w) dig_data = w_dig_pad[w*64 +: 64];
                end
            end
            default: ;
        endcase
    end

    // Key capture when a new message is accepted.
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_key_q <= '0;
        end else if (w_start_acc) begin
            r_key_q <= key_in;
        end
    end

    // Message word and last flag, held through ABS_V/ABS_H and beyond.
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_din_q  <= '0;
            r_last_q <= 1'b0;
        end else if (w_msg_acc) begin
            r_din_q  <= msg_data;
            r_last_q <= msg_last;
        end
    end

    // Saturating count of accepted words, cleared on each new message.
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_words <= '0;
        end else if (w_start_acc) begin
            r_words <= '0;
        end else if (w_msg_acc && (r_words != '1)) begin
            r_words <= r_words + 1'b1;
        end
    end

    // Digest capture at the squeeze edge and output word index.
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_dig_q <= '0;
            r_idx   <= '0;
        end else if (r_state == S_SQZ) begin
            r_dig_q <= loby_dout;
            r_idx   <= '0;
        end else if (w_dig_acc && !w_idx_last) begin
            r_idx   <= r_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_loby_driver.sv
// Self-checking bench for loby_driver: directed timing cases plus randomized
// messages, checked against transaction-level expectations.
module tb_loby_driver;

    logic         clk = 1'b0;
    logic         arstn, start, msg_valid, msg_last, dig_ready;
    logic [256:0] key_in, loby_dout;
    logic [63:0]  msg_data;

    logic         msg_ready, loby_init, loby_din_valid, loby_sqz, dig_valid, dig_last, busy;
    logic [256:0] loby_key;
    logic [63:0]  loby_din, dig_data;
    logic [15:0]  words_absorbed;

    logic         s_msg_ready, s_loby_init, s_loby_din_valid, s_loby_sqz, s_dig_valid, s_dig_last, s_busy;
    logic [256:0] s_loby_key;
    logic [63:0]  s_loby_din, s_dig_data;
    logic [1:0]   s_words;

    always #5 clk = ~clk;

    loby_driver u_dut (
        .clk(clk), .arstn(arstn), .start(start), .key_in(key_in),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
        .loby_init(loby_init), .loby_key(loby_key), .loby_din(loby_din),
        .loby_din_valid(loby_din_valid), .loby_sqz(loby_sqz), .loby_dout(loby_dout),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_last(dig_last), .dig_ready(dig_ready),
        .busy(busy), .words_absorbed(words_absorbed)
    );

    loby_driver #(.CNT_W(2)) u_sat (
        .clk(clk), .arstn(arstn), .start(start), .key_in(key_in),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(s_msg_ready),
        .loby_init(s_loby_init), .loby_key(s_loby_key), .loby_din(s_loby_din),
        .loby_din_valid(s_loby_din_valid), .loby_sqz(s_loby_sqz), .loby_dout(loby_dout),
        .dig_data(s_dig_data), .dig_valid(s_dig_valid), .dig_last(s_dig_last), .dig_ready(dig_ready),
        .busy(s_busy), .words_absorbed(s_words)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [256:0] rand257();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[32*i +: 32] = $urandom;
        return t[256:0];
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural core: dout changes every cycle so a mistimed capture is visible.
    bit core_ones = 1'b0;
    always @(posedge clk) loby_dout <= core_ones ? {257{1'b1}} : rand257();

    // Observation monitor: records what the core and the streams see.
    int unsigned  m_init, m_sqzn, m_viol, m_hs;
    logic [63:0]  m_din[$];
    bit           m_sqz[$];
    logic [63:0]  m_dig[$];
    bit           m_last[$];
    logic [256:0] m_snap;
    bit           p_dv, p_dvalid, p_drdy, p_dlast;
    logic [63:0]  p_din, p_ddata;

    task automatic mon_clear();
        m_init = 0; m_sqzn = 0; m_viol = 0; m_hs = 0; m_snap = '0;
        m_din.delete(); m_sqz.delete(); m_dig.delete(); m_last.delete();
    endtask

    always @(negedge clk) begin
        if (arstn) begin
            p_dv = 1'b0; p_dvalid = 1'b0; p_drdy = 1'b0;
        end else begin
            if (loby_init) begin
                m_init++;
                if (loby_din_valid || loby_sqz) m_viol++;
            end
            if (loby_din_valid) begin
                m_din.push_back(loby_din);
                if (loby_sqz) m_viol++;
            end
            if (p_dv) begin
                m_sqz.push_back(loby_sqz);
                if (loby_din_valid || loby_din !== p_din) m_viol++;
            end
            if (loby_sqz) begin
                m_sqzn++;
                if (m_sqzn == 2) m_snap = loby_dout;
            end
            if (msg_valid && msg_ready) m_hs++;
            if (p_dvalid && !p_drdy && (!dig_valid || dig_data !== p_ddata || dig_last !== p_dlast)) m_viol++;
            if (dig_valid && dig_ready) begin
                m_dig.push_back(dig_data);
                m_last.push_back(dig_last);
            end
            // The narrow-counter instance must behave identically apart from its count.
            if ({s_msg_ready, s_loby_init, s_loby_key, s_loby_din, s_loby_din_valid, s_loby_sqz,
                 s_dig_data, s_dig_valid, s_dig_last, s_busy} !==
                {msg_ready, loby_init, loby_key, loby_din, loby_din_valid, loby_sqz,
                 dig_data, dig_valid, dig_last, busy}) m_viol++;
            p_dv = loby_din_valid; p_din = loby_din;
            p_dvalid = dig_valid; p_drdy = dig_ready; p_ddata = dig_data; p_dlast = dig_last;
        end
    end

    // Single-word message with cycle-exact checks of the core-facing timing.
    task automatic directed_one();
        logic [256:0] k, snap;
        logic [63:0]  w;
        k = '0; k[256] = 1'b1; k[0] = 1'b1;
        w = 64'h0123_4567_89AB_CDEF;
        mon_clear(); core_ones = 1'b0;
        start = 1'b1; key_in = k; msg_valid = 1'b1; msg_data = w; msg_last = 1'b1;
        tick(); start = 1'b0; key_in = rand257();
        chk("d_init", {loby_init, loby_din_valid, loby_sqz, busy, msg_ready}, 5'b10010);
        tick();
        chk("d_init_gap", {loby_init, loby_din_valid, loby_sqz, msg_ready}, 4'b0000);
        chk("d_key", loby_key, k);
        tick();
        chk("d_wait", {loby_init, loby_din_valid, loby_sqz, msg_ready}, 4'b0001);
        tick();
        chk("d_absv", {loby_din_valid, loby_sqz, msg_ready}, 3'b100);
        chk("d_absv_din", loby_din, w);
        chk("d_cnt", words_absorbed, 1);
        tick();
        chk("d_absh", {loby_init, loby_din_valid, loby_sqz}, 3'b001);
        chk("d_absh_din", loby_din, w);
        msg_valid = 1'b0;
        tick();
        chk("d_sqz_gap", {loby_init, loby_din_valid, loby_sqz, dig_valid}, 4'b0000);
        tick();
        chk("d_sqz", {loby_init, loby_din_valid, loby_sqz, dig_valid}, 4'b0010);
        snap = loby_dout;
        tick();
        chk("d_out", {loby_sqz, dig_valid}, 2'b01);
        for (int i = 0; i < 5; i++) begin
            chk("d_dig", dig_data, 64'(snap >> (64 * i)));
            chk("d_last", {dig_valid, dig_last}, {1'b1, (i == 4)});
            dig_ready = 1'b1;
            tick();
        end
        dig_ready = 1'b0;
        chk("d_idle", busy, 0);
        chk("d_counts", {8'(m_init), 8'(m_hs)}, {8'd1, 8'd1});
    endtask

    // Asynchronous reset while a word is being presented to the core.
    task automatic reset_test();
        mon_clear();
        start = 1'b1; key_in = rand257(); msg_valid = 1'b1; msg_data = 64'hDEAD_BEEF_0000_0001; msg_last = 1'b0;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("r_absv", loby_din_valid, 1);
        #2 arstn = 1'b1;
        @(posedge clk); #1;
        chk("r_ctl", {loby_init, loby_din_valid, loby_sqz, msg_ready, dig_valid, dig_last, busy}, 0);
        chk("r_data", {loby_din, dig_data}, 0);
        chk("r_key", loby_key, 0);
        chk("r_cnt", {words_absorbed, s_words}, 0);
        msg_valid = 1'b0; arstn = 1'b0;
        tick();
        chk("r_idle", busy, 0);
    endtask

    // One full message: random valid gaps, digest backpressure, optional start noise.
    task automatic run_msg(input int unsigned n, input int unsigned vprob, input int unsigned rwait,
                           input bit noise, input bit ones);
        logic [63:0]  words[$];
        logic [256:0] key, dexp;
        int unsigned  idx, got, waitc, budget;
        bit           acc;
        mon_clear(); core_ones = ones;
        for (int unsigned i = 0; i < n; i++) words.push_back({$urandom, $urandom});
        key = rand257();
        start = 1'b1; key_in = key;
        tick(); start = 1'b0;
        idx = 0; budget = 400;
        while (idx < n && budget != 0) begin
            msg_data  = words[idx];
            msg_last  = (idx == n - 1);
            msg_valid = ($urandom_range(99) < vprob);
            if (noise && msg_ready && $urandom_range(3) == 0) begin
                start = 1'b1; key_in = rand257();
            end
            acc = msg_valid && msg_ready;
            tick(); start = 1'b0; budget--;
            if (acc) begin
                idx++;
                chk("cnt", words_absorbed, sat(idx, 65535));
                chk("cnt_sat", s_words, sat(idx, 3));
            end
        end
        msg_valid = 1'b0;
        chk("absorb_done", idx, n);
        got = 0; waitc = 0; budget = 400;
        while (got < 5 && budget != 0) begin
            dig_ready = dig_valid && (waitc >= rwait);
            if (dig_valid && !dig_ready) waitc++;
            if (noise && dig_valid && ((got == 4) ? dig_ready : ($urandom_range(1) == 1))) begin
                start = 1'b1; key_in = rand257();
            end
            acc = dig_valid && dig_ready;
            tick(); start = 1'b0; budget--;
            if (acc) begin
                got++; waitc = 0;
            end
        end
        dig_ready = 1'b0;
        chk("digest_done", got, 5);
        chk("end_state", {busy, loby_init}, 2'b00);
        chk("init_count", m_init, 1);
        chk("hs_count", m_hs, n);
        chk("sqz_cycles", m_sqzn, 2);
        chk("din_count", m_din.size(), n);
        for (int unsigned i = 0; i < n && i < m_din.size(); i++) begin
            chk("din_word", m_din[i], words[i]);
            if (i < m_sqz.size()) chk("absh_sqz", m_sqz[i], (i == n - 1));
        end
        dexp = ones ? {257{1'b1}} : m_snap;
        chk("dig_count", m_dig.size(), 5);
        for (int i = 0; i < 5 && i < m_dig.size(); i++) begin
            chk("dig_word", m_dig[i], 64'(dexp >> (64 * i)));
            chk("dig_last", m_last[i], (i == 4));
        end
        chk("key_hold", loby_key, key);
        chk("words_final", {words_absorbed, s_words}, {16'(sat(n, 65535)), 2'(sat(n, 3))});
        chk("violations", m_viol, 0);
    endtask

    initial begin
        arstn = 1'b1; start = 1'b0; key_in = '0; msg_data = '0; msg_valid = 1'b0;
        msg_last = 1'b0; dig_ready = 1'b0;
        mon_clear();
        tick(); tick();
        chk("rst_ctl", {loby_init, loby_din_valid, loby_sqz, msg_ready, dig_valid, dig_last, busy}, 0);
        chk("rst_data", {loby_din, dig_data, words_absorbed, s_words}, 0);
        chk("rst_key", loby_key, 0);
        arstn = 1'b0;
        tick();
        chk("rst_idle", busy, 0);
        directed_one();
        reset_test();
        run_msg(3, 50, 0, 1'b0, 1'b0);
        run_msg(3, 100, 4, 1'b0, 1'b1);
        run_msg(5, 70, 1, 1'b1, 1'b0);
        run_msg(1, 100, 0, 1'b1, 1'b0);
        for (int r = 0; r < 12; r++) begin
            run_msg($urandom_range(1, 8), $urandom_range(30, 100), $urandom_range(0, 3),
                    1'($urandom_range(1)), 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/loby_driver.md
Name: loby_driver

Overview:
- Host-side sequencer that drives the LoBy absorb/squeeze core's control and data inputs and collects its 257-bit digest.
- Latches a 257-bit key on `start`, then issues the init pulse.
- Accepts 64-bit message words over a valid/ready stream and feeds each word to the core with the two-cycle din timing the core requires.
- Applies domain separation on the last word, performs one squeeze, and returns the digest as five 64-bit words over a valid/ready stream.

Parameters:
- CNT_W, 16, width of the absorbed-word counter (saturating).
- DIG_WORDS, 5, number of 64-bit digest output words; ceil(257/64).

Ports:
- clk  input  1  clock; all logic on rising edge.
- arstn  input  1  reset, asynchronous, active-high (1 = reset asserted).
- start  input  1  begin a new message; sampled only in IDLE.
- key_in  input  257  key; captured into key_q when start is accepted.
- msg_data  input  64  message word.
- msg_valid  input  1  msg_data valid.
- msg_last  input  1  marks the final word of the message; qualified by msg_valid.
- msg_ready  output  1  driver accepts the word this cycle.
- loby_init  output  1  to core init.
- loby_key  output  257  to core key; always equals key_q.
- loby_din  output  64  to core din.
- loby_din_valid  output  1  to core din_valid.
- loby_sqz  output  1  to core sqz.
- loby_dout  input  257  from core dout.
- dig_data  output  64  digest word.
- dig_valid  output  1  digest word valid.
- dig_last  output  1  high with the final digest word.
- dig_ready  input  1  consumer accepts the digest word.
- busy  output  1  high in every state except IDLE.
- words_absorbed  output  CNT_W  count of message words accepted since the last start; saturates at all-ones.

Behaviour:
- Output timing: all loby_* and dig_* outputs are registered or decoded from state. There is no combinational path from msg_*/dig_ready to loby_*.
- Reset values: state=IDLE; every output 0; key_q, din_q, dig_q 0; counters 0. Reset mid-operation aborts immediately and drops every loby_* control to 0 on the next edge.
- State machine (one state per cycle unless a wait is noted):
  - IDLE: if start=1 → capture key_in, clear words_absorbed → INIT. Otherwise remain in IDLE.
  - INIT: loby_init=1 → INIT_GAP.
  - INIT_GAP: all loby controls 0; the core loads the key this cycle → WAIT_W.
  - WAIT_W: msg_ready=1. On msg_valid: din_q<=msg_data, last_q<=msg_last, words_absorbed+=1 (saturating) → ABS_V. Otherwise stay.
  - ABS_V: loby_din_valid=1, loby_din=din_q → ABS_H.
  - ABS_H: loby_din_valid=0, loby_din held at din_q; the core absorbs this cycle. loby_sqz=last_q, which sets the domain bit 256. If last_q → SQZ_GAP, else → WAIT_W.
  - SQZ_GAP: all loby controls 0; the core's saved sqz flag clears → SQZ.
  - SQZ: loby_sqz=1; dig_q<=loby_dout captured at this edge; idx<=0 → OUT.
  - OUT: dig_valid=1.
    - dig_data = dig_q[64*idx+63:64*idx] for idx 0..3.
    - For idx 4: dig_data = {63'b0, dig_q[256]}.
    - dig_last=(idx==DIG_WORDS-1).
    - On dig_ready: if last → IDLE, else idx+=1.
    - dig_data/dig_valid are held stable until accepted.
- loby_din keeps its last value when not absorbing; it is 0 only after reset.
- msg_ready is low outside WAIT_W. msg_valid outside WAIT_W is ignored, and the word stays pending at the source.
- start outside IDLE is ignored. A start in the same cycle that OUT completes is ignored; the driver re-enters IDLE first.
- Message length: minimum 1 word. An empty message is not supported; the source must send one word with msg_last=1.
- Throughput: ≥3 cycles per word (WAIT_W, ABS_V, ABS_H). Total fixed overhead is 2 (init) + 2 (squeeze) + 5 (output) cycles with no backpressure.

Test Plan:
- Reset during ABS_V with loby_din_valid=1 → next cycle all outputs 0, state IDLE, busy=0; after release, start is accepted normally.
- start with key_in=257'h1_0000…_0001, then 1 word 64'h0123_4567_89AB_CDEF with msg_last=1 and msg_valid held high. Required response:
  - loby_init high exactly 1 cycle.
  - loby_din_valid high 1 cycle with loby_din=0123…CDEF, with loby_sqz=0 in that cycle.
  - Next cycle: loby_din still 0123…CDEF, din_valid=0, loby_sqz=1.
  - Next cycle: all loby controls 0.
  - Next cycle: loby_sqz=1.
  - words_absorbed=1.
  - dig_valid rises 1 cycle later.
- 3-word message (words 1, 2, 3; last on word 3) with msg_valid toggling → exactly 3 handshakes. loby_sqz asserts only in the ABS_H after word 3. words_absorbed=3.
- Digest output with a behavioural core model returning dout=257'h1_FFFF…_FFFF (all ones) and dig_ready low for 4 cycles per word → five words, all held stable while waiting. Words 0–3 are 64'hFFFF_FFFF_FFFF_FFFF; word 4 is 64'h1 with dig_last=1. Then IDLE.
- start pulsed during WAIT_W and during OUT → ignored; key_q unchanged and loby_init stays 0.
- words_absorbed saturation with CNT_W=2 and a 5-word message → counter 1, 2, 3, 3, 3; absorption unaffected, 5 din_valid pulses.
